// File: rtl/m_stopwatch_cnt_pkg.sv
// Shared types and digit limits for the MM:SS.cc stopwatch counter.
package pkg_stopwatch;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} t_sw_state;
  typedef logic [3:0] t_bcd;

  localparam t_bcd C_CS_MAX       = 4'd9;
  localparam t_bcd C_SEC_TENS_MAX = 4'd5;

  // Static upper bound of digit idx (0 = cs ones ... 5 = min tens).
  function automatic int f_digit_max(input int idx, input int min_max);
    case (idx)
      3:       return int'(C_SEC_TENS_MAX);
      5:       return min_max / 10;
      default: return int'(C_CS_MAX);
    endcase
  endfunction

endpackage

// File: rtl/m_stopwatch_cnt_bcd_digit.sv
// One BCD counter digit; wraps to 0 after reaching its limit and
// signals carry combinationally in the cycle it wraps.
module m_bcd_digit #(
  parameter int P_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [3:0] i_max,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [3:0] r_digit;
  logic [3:0] w_lim;

  // Runtime limit can only tighten the static bound.
  assign w_lim = (i_max > 4'(P_MAX)) ? 4'(P_MAX) : i_max;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_digit <= 4'd0;
    else if (i_en)
      r_digit <= (r_digit >= w_lim) ? 4'd0 : r_digit + 4'd1;
  end

  assign o_digit = r_digit;
  assign o_carry = i_en & (r_digit == w_lim);

endmodule

// File: rtl/m_stopwatch_cnt.sv
// Stopwatch counter: consumes the 10 ms time base and counts MM:SS.cc in BCD
// under a start/stop/clear FSM.
module m_stopwatch_cnt
  import pkg_stopwatch::*;
#(
  parameter int P_MIN_MAX       = 59,
  parameter bit P_TICK_IS_PULSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk10ms,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [7:0] o_cs,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic       o_running,
  output logic       o_wrap
);

  localparam t_bcd C_MIN_TENS_MAX = t_bcd'(P_MIN_MAX / 10);
  localparam t_bcd C_MIN_ONES_TOP = t_bcd'(P_MIN_MAX % 10);

  t_sw_state        r_state;
  logic             r_running;
  logic             r_wrap;
  logic             r_clk10ms_q;
  logic             w_tick;
  logic             w_cnt;
  logic             w_clr;
  logic [5:0]       w_en;
  logic [5:0]       w_carry;
  logic [5:0][3:0]  w_dig;
  logic [5:0][3:0]  w_lim;
  t_bcd             w_min_ones_lim;

  always_ff @(posedge clk) begin
    if (rst) r_clk10ms_q <= 1'b0;
    else     r_clk10ms_q <= clk10ms;
  end

  assign w_tick = P_TICK_IS_PULSE ? clk10ms : (clk10ms & ~r_clk10ms_q);
  assign w_cnt  = w_tick & (r_state == RUN);
  // Clear is only honoured while stopped or idle.
  assign w_clr  = i_clear & (r_state != RUN);

  assign w_min_ones_lim = (w_dig[5] == C_MIN_TENS_MAX) ? C_MIN_ONES_TOP : 4'd9;
  assign w_lim = {C_MIN_TENS_MAX, w_min_ones_lim, C_SEC_TENS_MAX,
                  4'd9, C_CS_MAX, C_CS_MAX};
  assign w_en  = {w_carry[4:0], w_cnt};

  for (genvar g = 0; g < 6; g++) begin : g_dig
    m_bcd_digit #(
      .P_MAX(f_digit_max(g, P_MIN_MAX))
    ) u_dig (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_en[g]),
      .i_max  (w_lim[g]),
      .o_digit(w_dig[g]),
      .o_carry(w_carry[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= w_cnt & w_carry[5];
      case (r_state)
        IDLE: if (i_start_stop) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        RUN: if (i_start_stop) begin
          r_state   <= STOP;
          r_running <= 1'b0;
        end
        STOP: if (i_start_stop) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end else if (i_clear) begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_cs      = {w_dig[1], w_dig[0]};
  assign o_sec     = {w_dig[3], w_dig[2]};
  assign o_min     = {w_dig[5], w_dig[4]};
  assign o_running = r_running;
  assign o_wrap    = r_wrap;

endmodule

// File: doc/m_stopwatch_cnt.md
Name: m_stopwatch_cnt

Overview:
Consumer side of the 10 ms time base in the L13 stopwatch.
- Takes the `clk10ms` output of `m_10ms_clk` and counts elapsed time as BCD digits MM:SS.cc (centiseconds).
- Start/stop and clear are controlled by single-cycle button pulses.
- Outputs drive the 7-seg display decoder.

Parameters:
- P_MIN_MAX, 59: highest minutes value. After P_MIN_MAX:59.99 the count wraps to 00:00.00. Legal range 1..99.
- P_TICK_IS_PULSE, 0: selects how `clk10ms` is interpreted.
  - 0: `clk10ms` is a square wave; one tick per rising edge.
  - 1: `clk10ms` is already a one-`clk` pulse; each high cycle is one tick.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- clk10ms  in  1  10 ms time base from `m_10ms_clk`; synchronous to `clk`
- i_start_stop  in  1  one-cycle pulse; toggles run/stop
- i_clear  in  1  one-cycle pulse; zeroes the count when not running
- o_cs  out  8  centiseconds as BCD {tens, ones}, 00..99
- o_sec  out  8  seconds as BCD {tens, ones}, 00..59
- o_min  out  8  minutes as BCD {tens, ones}, 00..P_MIN_MAX
- o_running  out  1  high while in RUN
- o_wrap  out  1  one-cycle pulse on wrap to 00:00.00

Behaviour:
Reset and clocking
- One clock; reset is synchronous and active-high.
- On rst: all digits 0, state IDLE, o_running=0, o_wrap=0, edge-detect register=0.
- rst wins over all other inputs in the same cycle.

Tick detection
- P_TICK_IS_PULSE=0: tick = clk10ms & ~clk10ms_q, where clk10ms_q is clk10ms registered.
- P_TICK_IS_PULSE=1: tick = clk10ms.
- tick is combinational from the current input.
- Counter update appears on the outputs at the next `clk` edge, i.e. 1-cycle latency from the first high sample.

FSM states: IDLE (zeroed, stopped), RUN, STOP (held, non-zero allowed).
- IDLE --start_stop--> RUN
- RUN --start_stop--> STOP
- STOP --start_stop--> RUN (resumes from the held value)
- STOP --clear--> IDLE (digits zeroed next cycle)
- IDLE --clear--> IDLE (no effect)
- RUN: clear is ignored, no lap function.
- start_stop and clear in the same cycle:
  - in RUN: start_stop acts, clear is ignored; result is STOP with the value held.
  - in STOP/IDLE: clear is applied and start_stop is applied as well; result is RUN starting from 00:00.00.
- o_running = (state==RUN), registered.

Counting
- A tick is counted only if the current state is RUN.
  - A tick in the same cycle as a stop press is counted.
  - A tick in the same cycle as a start press from IDLE/STOP is not counted.
- Digit chain, each digit 4-bit BCD, carries rippling combinationally within one cycle:
  - cs_ones 0..9
  - cs_tens 0..9
  - sec_ones 0..9
  - sec_tens 0..5
  - min_ones 0..9 (or P_MIN_MAX%10 when min_tens==P_MIN_MAX/10)
  - min_tens 0..P_MIN_MAX/10
- Full carry at P_MIN_MAX:59.99 + tick: all digits 0 and o_wrap=1 for exactly one cycle; state stays RUN.
- Digits never take non-BCD values (A–F).

Decomposition:
- Package pkg_stopwatch:
  - typedef enum logic [1:0] {IDLE, RUN, STOP} t_sw_state
  - typedef logic [3:0] t_bcd
  - constants C_CS_MAX=9, C_SEC_TENS_MAX=5
- Sub-module m_bcd_digit, instantiated six times:
  - params P_MAX
  - ports clk, rst, i_clr, i_en, i_max (runtime limit override for the minutes ones digit), o_digit, o_carry
  - o_carry = i_en & (digit==limit), combinational

Test Plan:
- rst high 10 cycles, then low -> all outputs 0, o_running=0, state IDLE.
- start pulse, drive 100 ticks at 10 ms (P_TICK_IS_PULSE=0, square wave) -> o_cs=8'h00, o_sec=8'h01, o_running=1; each output change lands 1 cycle after the clk10ms rising edge.
- run 250 ticks, stop, hold 50 ticks, start, 50 more ticks -> o_sec=8'h03, o_cs=8'h00; no change while stopped; clear pulse in RUN ignored.
- preload to 59:59.99 by running 359999 ticks (fast 1-cycle pulse, P_TICK_IS_PULSE=1), one more tick -> all outputs 8'h00, o_wrap high exactly 1 cycle, o_running stays 1.
- stop at 00:12.34, then start_stop+clear same cycle -> next cycle digits 00:00.00, o_running=1; a tick coincident with a start press is not counted.
- rst asserted mid-RUN at 00:05.67 coincident with a tick -> next cycle all zeros, IDLE, o_wrap=0.
